// File: rtl/demod_stream_ctrl_if.sv
// Valid/ready stream bundle used on both sides of the demodulator controller.
// The master drives data/valid and the slave answers with ready.
interface demod_stream_ctrl_if #(
  parameter int W = 12
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/demod_stream_ctrl.sv
// Demodulator stream controller: brings ADC samples across from the ADC clock
// domain, hands them to the rectifier/FIR sink, holds the DAC output while the
// filter refills, and drops to a safe midscale output when samples stop.
module demod_stream_ctrl #(
  parameter int unsigned FILL_LEN = 32,
  parameter int unsigned TIMEOUT  = 1023,
  parameter logic [13:0] MIDSCALE = 14'h2000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_en,
  input  logic                        i_clr,
  input  logic                        i_clk_adc,
  input  logic [11:0]                 i_adc_data,
  demod_stream_ctrl_if.master         snk,
  demod_stream_ctrl_if.slave          src,
  output logic [13:0]                 o_dac_data,
  output logic                        o_dac_update,
  output logic [1:0]                  o_state,
  output logic                        o_overrun
);

  localparam int FCW = $clog2(FILL_LEN) + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0] FILL_LAST = FCW'(FILL_LEN - 1);
  localparam logic [WDW-1:0] WD_MAX    = WDW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic [FCW-1:0]   r_fill_cnt;
  logic [WDW-1:0]   r_wdog;
  logic [13:0]      r_dac_data;
  logic             r_dac_update;
  logic [11:0]      r_snk_data;
  logic             r_snk_valid;
  logic             r_overrun;

  logic             w_strobe;
  logic             w_xfer;
  logic             w_active;
  logic             w_wd_hit;
  logic             w_accept;
  logic             w_drop;
  logic             w_load;
  logic             w_ovr_evt;
  logic             w_fill_done;
  logic [WDW-1:0]   w_wdog_nxt;

  // One clk cycle of strobe per rising edge of the synchronized ADC clock.
  assign w_strobe    = r_sync2 & ~r_sync3;
  assign w_xfer      = r_snk_valid & snk.ready;
  assign w_active    = (r_state == ST_FILL) || (r_state == ST_RUN);
  assign w_wd_hit    = w_active && (r_wdog == WD_MAX);
  assign w_accept    = w_strobe && (r_state != ST_IDLE);
  // Leaving for IDLE (enable low) or FAULT (watchdog) discards the pending sample.
  assign w_drop      = !i_en || w_wd_hit;
  assign w_load      = w_accept && !w_drop;
  // A replacement is an overrun only if the old sample did not leave this cycle.
  assign w_ovr_evt   = w_load && r_snk_valid && !w_xfer;
  assign w_fill_done = src.valid && (r_fill_cnt == FILL_LAST);
  // Watchdog restarts on every strobe and saturates at the limit.
  assign w_wdog_nxt  = w_strobe ? {WDW{1'b0}} :
                       (r_wdog == WD_MAX) ? r_wdog : r_wdog + WDW'(1);

  assign src.ready    = 1'b1;
  assign snk.data     = r_snk_data;
  assign snk.valid    = r_snk_valid;
  assign o_dac_data   = r_dac_data;
  assign o_dac_update = r_dac_update;
  assign o_state      = r_state;
  assign o_overrun    = r_overrun;

  // Two-flop synchronizer plus an edge-detect flop for the ADC clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_clk_adc;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Run-state machine with fill counter, watchdog and the held DAC output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fill_cnt   <= {FCW{1'b0}};
      r_wdog       <= {WDW{1'b0}};
      r_dac_data   <= MIDSCALE;
      r_dac_update <= 1'b0;
    end else if (!i_en) begin
      r_state      <= ST_IDLE;
      r_fill_cnt   <= {FCW{1'b0}};
      r_wdog       <= {WDW{1'b0}};
      r_dac_data   <= MIDSCALE;
      r_dac_update <= 1'b0;
    end else begin
      r_dac_update <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_FILL;
          r_fill_cnt <= {FCW{1'b0}};
          r_wdog     <= {WDW{1'b0}};
          r_dac_data <= MIDSCALE;
        end
        ST_FILL: begin
          if (w_wd_hit) begin
            r_state    <= ST_FAULT;
            r_wdog     <= {WDW{1'b0}};
            r_dac_data <= MIDSCALE;
          end else if (w_fill_done) begin
            r_state    <= ST_RUN;
            r_wdog     <= {WDW{1'b0}};
          end else begin
            r_wdog <= w_wdog_nxt;
            if (src.valid) begin
              r_fill_cnt <= r_fill_cnt + FCW'(1);
            end else begin
              r_fill_cnt <= r_fill_cnt;
            end
          end
        end
        ST_RUN: begin
          if (w_wd_hit) begin
            r_state    <= ST_FAULT;
            r_wdog     <= {WDW{1'b0}};
            r_dac_data <= MIDSCALE;
          end else begin
            r_wdog <= w_wdog_nxt;
            if (src.valid) begin
              r_dac_data   <= 14'(src.data);
              r_dac_update <= 1'b1;
            end else begin
              r_dac_data   <= r_dac_data;
            end
          end
        end
        ST_FAULT: begin
          if (w_accept) begin
            r_state    <= ST_FILL;
            r_fill_cnt <= {FCW{1'b0}};
            r_wdog     <= {WDW{1'b0}};
            r_dac_data <= MIDSCALE;
          end else begin
            r_state    <= ST_FAULT;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_fill_cnt <= {FCW{1'b0}};
          r_wdog     <= {WDW{1'b0}};
          r_dac_data <= MIDSCALE;
        end
      endcase
    end
  end

  // Sink holding register: load on accepted strobe, release after transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snk_data  <= 12'h000;
      r_snk_valid <= 1'b0;
    end else if (w_drop) begin
      r_snk_valid <= 1'b0;
    end else if (w_load) begin
      r_snk_data  <= i_adc_data;
      r_snk_valid <= 1'b1;
    end else if (w_xfer) begin
      r_snk_valid <= 1'b0;
    end else begin
      r_snk_valid <= r_snk_valid;
    end
  end

  // Sticky overrun flag; a new event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_evt) begin
      r_overrun <= 1'b1;
    end else if (i_clr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

endmodule

// File: tb/tb_demod_stream_ctrl.sv
// Bench for demod_stream_ctrl: a 5-cycle FIR model feeds a scoreboard of
// expected DAC values; directed phases cover overrun, coincident transfer,
// watchdog, enable drop and asynchronous reset.
module tb_demod_stream_ctrl;

  localparam logic [13:0] MID = 14'h2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        clk_adc = 1'b0;
  logic [11:0] adc_data = 12'h000;
  logic [13:0] dac_data;
  logic        dac_update;
  logic [1:0]  state;
  logic        overrun;

  demod_stream_ctrl_if #(.W(12)) snk_if ();
  demod_stream_ctrl_if #(.W(14)) src_if ();

  demod_stream_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .i_clr        (clr),
    .i_clk_adc    (clk_adc),
    .i_adc_data   (adc_data),
    .snk          (snk_if),
    .src          (src_if),
    .o_dac_data   (dac_data),
    .o_dac_update (dac_update),
    .o_state      (state),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // FIR model and scoreboard state
  bit          fir_on = 1'b0;
  bit          mon_en = 1'b0;
  bit          cap_v = 1'b0;
  logic [11:0] cap_d = 12'h000;
  logic        pv [5] = '{default: 1'b0};
  logic [13:0] pd [5] = '{default: 14'h0000};
  int          fir_k = 0;
  int          fir_base = 0;
  int          cur_k = 0;
  int          samp_k = 0;
  logic [13:0] sb_q [$];
  int          cyc = 0;
  int          xfer_cnt = 0;
  logic [11:0] last_d = 12'h000;
  logic [11:0] prev_d = 12'h000;
  int          last_c = 0;
  int          prev_c = 0;

  // Sample handshake and FIR input just before the DUT updates at the edge.
  always @(posedge clk) begin
    cyc++;
    cap_v = fir_on && snk_if.valid && snk_if.ready;
    cap_d = snk_if.data;
    if (rst_n && snk_if.valid && snk_if.ready) begin
      xfer_cnt++;
      prev_d = last_d; prev_c = last_c;
      last_d = snk_if.data; last_c = cyc;
    end
    samp_k = src_if.valid ? cur_k : 0;
  end

  // FIR delay line: push expected DAC values for outputs past the fill length.
  always @(negedge clk) begin
    for (int i = 4; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = cap_v;
    pd[0] = {2'b10, cap_d} ^ 14'h0A5A;
    src_if.valid = pv[4];
    src_if.data  = pd[4];
    if (pv[4]) begin
      fir_k++;
      cur_k = fir_k - fir_base;
      if (cur_k > 32) sb_q.push_back(pd[4]);
    end else begin
      cur_k = 0;
    end
  end

  // Output monitor: fill-phase holds and scoreboard pops on dac_update.
  always @(negedge clk) begin
    if (mon_en) begin
      if (samp_k >= 1 && samp_k <= 32) check_eq("fill_dac_mid", dac_data, MID);
      if (samp_k == 31) check_eq("fill_state", state, 2'd1);
      if (samp_k == 32) check_eq("run_entry", state, 2'd2);
      if (samp_k >= 33) check_eq("upd_latency", dac_update, 1'b1);
      if (sb_q.size() == 0) check_eq("dac_spurious", dac_update, 1'b0);
      else if (dac_update) check_eq("dac_out", dac_data, sb_q.pop_front());
    end
  end

  logic [11:0] adc_val = 12'h010;
  bit adc_stop = 1'b0;

  task automatic adc_pulse(input logic [11:0] d);
    @(negedge clk);
    adc_data = d;
    clk_adc = 1'b1;
    repeat (4) @(negedge clk);
    clk_adc = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_fill();
    int cnt;
    fir_base = fir_k;
    snk_if.ready = 1'b1;
    adc_stop = 1'b0;
    fork
      begin
        #3;
        while (!adc_stop) begin
          #40;
          clk_adc = ~clk_adc;
          if (!clk_adc) begin
            adc_val = adc_val + 12'd7;
            adc_data = adc_val;
          end
        end
        clk_adc = 1'b0;
      end
      begin
        fir_on = 1'b1;
        cnt = 0;
        while ((fir_k - fir_base) < 36 && cnt < 2000) begin
          @(negedge clk);
          cnt++;
        end
        check_eq("fill_progress", ((fir_k - fir_base) >= 36), 1'b1);
        fir_on = 1'b0;
        adc_stop = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("run_after_fill", state, 2'd2);
  endtask

  initial begin
    int x0;
    int cnt;
    snk_if.ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_snk_valid", snk_if.valid, 1'b0);
    check_eq("rst_snk_data", snk_if.data, 12'h000);
    check_eq("rst_dac", dac_data, MID);
    check_eq("rst_dac_upd", dac_update, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    en = 1'b1;
    @(negedge clk);
    check_eq("idle_to_fill", state, 2'd1);
    run_fill();

    // backpressure overrun
    snk_if.ready = 1'b0;
    adc_pulse(12'h100);
    check_eq("ovr_pend_valid", snk_if.valid, 1'b1);
    check_eq("ovr_pend_data", snk_if.data, 12'h100);
    check_eq("ovr_pre", overrun, 1'b0);
    adc_pulse(12'h200);
    check_eq("ovr_data", snk_if.data, 12'h200);
    check_eq("ovr_valid", snk_if.valid, 1'b1);
    check_eq("ovr_flag", overrun, 1'b1);
    x0 = xfer_cnt;
    @(negedge clk) snk_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    snk_if.ready = 1'b0;
    check_eq("ovr_one_xfer", xfer_cnt - x0, 1);
    check_eq("ovr_xfer_data", last_d, 12'h200);
    check_eq("ovr_valid_off", snk_if.valid, 1'b0);
    clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    check_eq("ovr_clr", overrun, 1'b0);

    // strobe coincident with transfer
    adc_pulse(12'h300);
    x0 = xfer_cnt;
    @(negedge clk);
    adc_data = 12'h400;
    clk_adc = 1'b1;
    @(negedge clk);
    @(negedge clk) snk_if.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clk_adc = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("coin_xfer_cnt", xfer_cnt - x0, 2);
    check_eq("coin_first", prev_d, 12'h300);
    check_eq("coin_second", last_d, 12'h400);
    check_eq("coin_consec", last_c - prev_c, 1);
    check_eq("coin_no_ovr", overrun, 1'b0);

    // watchdog
    check_eq("wd_run", state, 2'd2);
    repeat (1000) @(negedge clk);
    check_eq("wd_not_early", state, 2'd2);
    cnt = 0;
    while (state != 2'd3 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("wd_fault", state, 2'd3);
    check_eq("wd_dac_mid", dac_data, MID);
    check_eq("wd_snk_idle", snk_if.valid, 1'b0);
    adc_pulse(12'h555);
    check_eq("fault_to_fill", state, 2'd1);
    run_fill();

    // enable drop with pending sample
    snk_if.ready = 1'b0;
    adc_pulse(12'h123);
    check_eq("en_pend", snk_if.valid, 1'b1);
    @(negedge clk) en = 1'b0;
    @(negedge clk);
    check_eq("en_state", state, 2'd0);
    check_eq("en_snk_valid", snk_if.valid, 1'b0);
    check_eq("en_dac_mid", dac_data, MID);
    adc_pulse(12'h456);
    check_eq("idle_ignore_valid", snk_if.valid, 1'b0);
    check_eq("idle_ignore_state", state, 2'd0);

    // asynchronous reset mid-stream
    en = 1'b1;
    adc_pulse(12'h111);
    adc_pulse(12'h222);
    check_eq("ar_pre_ovr", overrun, 1'b1);
    check_eq("ar_pre_valid", snk_if.valid, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_state", state, 2'd0);
    check_eq("ar_snk_valid", snk_if.valid, 1'b0);
    check_eq("ar_snk_data", snk_if.data, 12'h000);
    check_eq("ar_dac", dac_data, MID);
    check_eq("ar_dac_upd", dac_update, 1'b0);
    check_eq("ar_overrun", overrun, 1'b0);
    #10 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demod_stream_ctrl.md
DEMOD_STREAM_CTRL -- requirements
Module: demod_stream_ctrl

Interface
REQ-001 Parameter FILL_LEN, default 32: number of filter outputs discarded after start, while the filter pipeline refills.
REQ-002 Parameter TIMEOUT, default 1023: clk cycles without a sample strobe before FAULT is entered.
REQ-003 Parameter MIDSCALE, default 14'h2000: DAC code driven when no valid output exists.
REQ-004 clk  in  1  system clock; all logic is synchronous to its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  run enable, synchronous to clk.
REQ-007 clr  in  1  one-cycle request that clears the sticky overrun flag.
REQ-008 clk_adc  in  1  ADC sample clock, asynchronous to clk.
REQ-009 adc_data  in  12  ADC sample, stable around the clk_adc rising edge.
REQ-010 snk_data  out  12  sample presented to the rectifier/FIR sink.
REQ-011 snk_valid  out  1  sink valid.
REQ-012 snk_ready  in  1  sink ready; a transfer occurs when snk_valid and snk_ready are both high at a clk edge.
REQ-013 src_data  in  14  FIR output data.
REQ-014 src_valid  in  1  FIR output valid (source ready is tied high; no backpressure).
REQ-015 dac_data  out  14  held DAC output.
REQ-016 dac_update  out  1  one-cycle pulse when dac_data loads a new filter value.
REQ-017 state  out  2  current state: IDLE=0, FILL=1, RUN=2, FAULT=3.
REQ-018 overrun  out  1  sticky flag: a sample was dropped.

Function
REQ-019 Sample strobe generation:
- clk_adc passes through a 2-flop synchronizer, then a third edge-detect flop.
- strobe = sync2 & ~sync3, exactly one clk cycle per clk_adc rising edge.
REQ-020 Strobe handling:
- Strobes are ignored in IDLE.
- Strobes are accepted in FILL, RUN and FAULT.
REQ-021 On an accepted strobe, adc_data is captured into snk_data, and snk_valid is high from the next cycle.
REQ-022 snk_valid holds, with snk_data stable, until the transfer cycle; it deasserts in the cycle after the transfer unless a new strobe loads a new sample.
REQ-023 Overrun on a strobe while a sample is still pending (snk_valid high, no transfer that cycle):
- The new sample replaces the pending one.
- snk_valid stays high.
- overrun is set.
REQ-024 Strobe and transfer in the same cycle: the old sample transfers, the new sample loads, snk_valid stays high, and no overrun is raised.
REQ-025 overrun clears on clr; if clr and a new overrun event coincide, overrun stays set.
REQ-026 State transitions:
- IDLE -> FILL when en=1.
- FILL -> RUN on the src_valid that completes FILL_LEN outputs.
- FILL/RUN -> FAULT when the watchdog reaches TIMEOUT.
- FAULT -> FILL on the next accepted strobe.
- en=0 forces IDLE from any state next cycle and has highest priority.
REQ-027 Fill counter: cleared on entry to FILL; increments on each src_valid while in FILL; width is clog2(FILL_LEN)+1.
REQ-028 Watchdog:
- Counts clk cycles in FILL and RUN.
- Clears on every strobe and on state entry.
- Saturates at TIMEOUT.
REQ-029 Output in RUN: on src_valid, dac_data <= src_data and dac_update = 1, both in the next cycle (one-cycle latency).
REQ-030 Output in FILL, FAULT and IDLE:
- On entry to these states, dac_data is loaded with MIDSCALE.
- dac_update stays 0.
- src_valid is ignored, except by the fill counter in FILL.
REQ-031 Entering IDLE or FAULT drops any pending sample: snk_valid = 0 next cycle.
REQ-032 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-033 With rst_n low, all of the following take these values immediately (asynchronously):
- state = IDLE
- snk_valid = 0, snk_data = 0
- dac_data = MIDSCALE, dac_update = 0
- overrun = 0
- synchronizer, fill counter and watchdog = 0
REQ-034 After rst_n deasserts, the first strobe can occur no earlier than the third clk edge.
REQ-035 Reset asserted mid-transfer discards the pending sample without a handshake.

Verification
REQ-036 Start-up fill: en=1, clk_adc = clk/8, snk_ready=1, FIR model delay of 5 cycles.
- dac_data stays 14'h2000 for the first 32 src_valid.
- state goes 1 -> 2.
- The 33rd src_data appears one cycle later with dac_update=1.
REQ-037 Backpressure overrun: snk_ready=0 across two strobes with samples 12'h100 then 12'h200.
- snk_data = 12'h200 and overrun = 1.
- With snk_ready=1, exactly one transfer occurs.
- clr then gives overrun = 0.
REQ-038 Coincident strobe and transfer: the two samples transfer in consecutive cycles, with no overrun.
REQ-039 Watchdog: stop clk_adc while in RUN.
- After 1023 cycles, state = 3 and dac_data = 14'h2000.
- Restarting clk_adc gives state = 1 on the first strobe.
REQ-040 Enable drop: en=0 in RUN with a sample pending.
- Next cycle: state = 0, snk_valid = 0, dac_data = 14'h2000.
- Strobes are then ignored.
REQ-041 Asynchronous reset pulse mid-stream: all outputs take their reset values without a clk edge.
